// File: rtl/sweep_acq_parser.sv
// Receive-side framer for the sweep-acquisition word stream: forwards index-tagged data words,
// emits one summary per DAC step and flags protocol errors.
module sweep_acq_parser #(
  parameter int unsigned PACKAGE_WORDS  = 11,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] InData,
  input  logic        InData_en,
  output logic [15:0] PackageData,
  output logic        PackageData_en,
  output logic [3:0]  PackageWordIndex,
  output logic [9:0]  CurrentDAC,
  output logic [9:0]  SummaryDAC,
  output logic [15:0] SummaryCount,
  output logic        Summary_en,
  output logic        SweepActive,
  output logic        SweepDone,
  output logic [2:0]  ErrorCode,
  output logic        Error_en
);
  localparam logic [15:0] Header   = 16'h5341;
  localparam logic [15:0] Tail     = 16'hFF45;
  localparam logic [5:0]  ParamTag = 6'b110100;
  localparam logic [3:0]  LastIdx  = 4'(PACKAGE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWaitParam, StPkgBoundary, StInPackage} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] count_q, count_d;
  logic        sat_seen_q, sat_seen_d;
  logic [23:0] gap_q, gap_d;
  logic        pkg_done;
  logic        is_param;

  logic [15:0] pkg_data_q, pkg_data_d;
  logic        pkg_data_en_q, pkg_data_en_d;
  logic [3:0]  pkg_idx_q, pkg_idx_d;
  logic [9:0]  cur_dac_q, cur_dac_d;
  logic [9:0]  sum_dac_q, sum_dac_d;
  logic [15:0] sum_count_q, sum_count_d;
  logic        sum_en_q, sum_en_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        err_en_q, err_en_d;

  assign is_param = (InData[15:10] == ParamTag);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    sat_seen_d    = sat_seen_q;
    gap_d         = gap_q;
    pkg_done      = 1'b0;
    pkg_data_d    = pkg_data_q;
    pkg_data_en_d = 1'b0;
    pkg_idx_d     = pkg_idx_q;
    cur_dac_d     = cur_dac_q;
    sum_dac_d     = sum_dac_q;
    sum_count_d   = sum_count_q;
    sum_en_d      = 1'b0;
    active_d      = active_q;
    done_d        = 1'b0;
    err_code_d    = err_code_q;
    err_en_d      = 1'b0;

    if (InData_en) begin
      gap_d = '0;
      unique case (state_q)
        StIdle: begin
          if (InData == Header) begin
            state_d  = StWaitParam;
            active_d = 1'b1;
          end
        end
        StWaitParam: begin
          if (is_param) begin
            cur_dac_d  = InData[9:0];
            count_d    = '0;
            sat_seen_d = 1'b0;
            idx_d      = '0;
            state_d    = StPkgBoundary;
          end else begin
            err_code_d = 3'd1;
            err_en_d   = 1'b1;
            active_d   = 1'b0;
            state_d    = StIdle;
          end
        end
        StPkgBoundary: begin
          if (is_param || InData == Tail) begin
            sum_en_d    = 1'b1;
            sum_dac_d   = cur_dac_q;
            sum_count_d = count_q;
          end
          if (is_param) begin
            // 1023 -> 0 is not a valid successor, so the wrapped sum alone is not enough.
            if (cur_dac_q == 10'h3FF || InData[9:0] != cur_dac_q + 10'd1) begin
              err_code_d = 3'd2;
              err_en_d   = 1'b1;
            end
            cur_dac_d  = InData[9:0];
            count_d    = '0;
            sat_seen_d = 1'b0;
          end else if (InData == Tail) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = StIdle;
          end else begin
            pkg_data_d    = InData;
            pkg_data_en_d = 1'b1;
            pkg_idx_d     = '0;
            if (LastIdx == 4'd0) begin
              pkg_done = 1'b1;
            end else begin
              idx_d   = 4'd1;
              state_d = StInPackage;
            end
          end
        end
        StInPackage: begin
          pkg_data_d    = InData;
          pkg_data_en_d = 1'b1;
          pkg_idx_d     = idx_q;
          if (idx_q == LastIdx) begin
            pkg_done = 1'b1;
            idx_d    = '0;
            state_d  = StPkgBoundary;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (gap_q == TIMEOUT_CYCLES - 24'd1) begin
        gap_d      = '0;
        idx_d      = '0;
        err_code_d = 3'd4;
        err_en_d   = 1'b1;
        active_d   = 1'b0;
        state_d    = StIdle;
      end else begin
        gap_d = gap_q + 24'd1;
      end
    end

    if (pkg_done) begin
      if (count_q == 16'hFFFF) begin
        if (!sat_seen_q) begin
          sat_seen_d = 1'b1;
          err_code_d = 3'd3;
          err_en_d   = 1'b1;
        end
      end else begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      count_q       <= '0;
      sat_seen_q    <= 1'b0;
      gap_q         <= '0;
      pkg_data_q    <= '0;
      pkg_data_en_q <= 1'b0;
      pkg_idx_q     <= '0;
      cur_dac_q     <= '0;
      sum_dac_q     <= '0;
      sum_count_q   <= '0;
      sum_en_q      <= 1'b0;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      err_code_q    <= '0;
      err_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      sat_seen_q    <= sat_seen_d;
      gap_q         <= gap_d;
      pkg_data_q    <= pkg_data_d;
      pkg_data_en_q <= pkg_data_en_d;
      pkg_idx_q     <= pkg_idx_d;
      cur_dac_q     <= cur_dac_d;
      sum_dac_q     <= sum_dac_d;
      sum_count_q   <= sum_count_d;
      sum_en_q      <= sum_en_d;
      active_q      <= active_d;
      done_q        <= done_d;
      err_code_q    <= err_code_d;
      err_en_q      <= err_en_d;
    end
  end

  assign PackageData      = pkg_data_q;
  assign PackageData_en   = pkg_data_en_q;
  assign PackageWordIndex = pkg_idx_q;
  assign CurrentDAC       = cur_dac_q;
  assign SummaryDAC       = sum_dac_q;
  assign SummaryCount     = sum_count_q;
  assign Summary_en       = sum_en_q;
  assign SweepActive      = active_q;
  assign SweepDone        = done_q;
  assign ErrorCode        = err_code_q;
  assign Error_en         = err_en_q;

endmodule

// File: tb/tb_sweep_acq_parser.sv
// Bench for sweep_acq_parser: a word-level protocol model predicts every output strobe and the
// cycle it appears in; observed strobes are logged and compared per scenario.
module tb_sweep_acq_parser;
  localparam int PW  = 11;
  localparam int TMO = 16;
  localparam logic [3:0] EvData = 4'd1;
  localparam logic [3:0] EvSum  = 4'd2;
  localparam logic [3:0] EvDone = 4'd3;
  localparam logic [3:0] EvErr  = 4'd4;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] InData = 16'h0000;
  logic        InData_en = 1'b0;
  logic [15:0] PackageData;
  logic        PackageData_en;
  logic [3:0]  PackageWordIndex;
  logic [9:0]  CurrentDAC;
  logic [9:0]  SummaryDAC;
  logic [15:0] SummaryCount;
  logic        Summary_en;
  logic        SweepActive;
  logic        SweepDone;
  logic [2:0]  ErrorCode;
  logic        Error_en;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] obs[$];
  logic [63:0] expq[$];

  // Protocol model: mode 0 idle, 1 awaiting DAC word, 2 sweep open; pos = word slot in package.
  int   m_mode, m_pos, m_dac, m_count, m_err, m_gap;
  bit   m_sat;
  logic m_active;

  sweep_acq_parser #(
    .PACKAGE_WORDS (PW),
    .TIMEOUT_CYCLES(24'(TMO))
  ) dut (
    .Clk             (Clk),
    .reset_n         (reset_n),
    .InData          (InData),
    .InData_en       (InData_en),
    .PackageData     (PackageData),
    .PackageData_en  (PackageData_en),
    .PackageWordIndex(PackageWordIndex),
    .CurrentDAC      (CurrentDAC),
    .SummaryDAC      (SummaryDAC),
    .SummaryCount    (SummaryCount),
    .Summary_en      (Summary_en),
    .SweepActive     (SweepActive),
    .SweepDone       (SweepDone),
    .ErrorCode       (ErrorCode),
    .Error_en        (Error_en)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] mk_ev(logic [3:0] t, int c, logic [39:0] p);
    return {t, c[19:0], p};
  endfunction

  initial forever begin
    @(posedge Clk);
    #1;
    cyc++;
    if (PackageData_en) obs.push_back(mk_ev(EvData, cyc, {20'd0, PackageWordIndex, PackageData}));
    if (Summary_en) obs.push_back(mk_ev(EvSum, cyc, {14'd0, SummaryDAC, SummaryCount}));
    if (SweepDone) obs.push_back(mk_ev(EvDone, cyc, 40'd0));
    if (Error_en) obs.push_back(mk_ev(EvErr, cyc, {37'd0, ErrorCode}));
  end

  function automatic void model_clear();
    m_mode = 0; m_pos = 0; m_dac = 0; m_count = 0; m_err = 0; m_gap = 0;
    m_sat = 1'b0; m_active = 1'b0;
  endfunction

  function automatic void model_close(int c);
    expq.push_back(mk_ev(EvSum, c, {14'd0, 10'(m_dac), 16'(m_count)}));
  endfunction

  function automatic void model_word(logic [15:0] w, int c);
    bit param;
    param = (w[15:10] == 6'b110100);
    m_gap = 0;
    if (m_mode == 0) begin
      if (w == 16'h5341) begin m_mode = 1; m_active = 1'b1; end
    end else if (m_mode == 1) begin
      if (param) begin
        m_dac = int'(w[9:0]); m_count = 0; m_sat = 1'b0; m_pos = 0; m_mode = 2;
      end else begin
        m_err = 1; m_active = 1'b0; m_mode = 0;
        expq.push_back(mk_ev(EvErr, c, 40'd1));
      end
    end else if (m_pos == 0 && param) begin
      model_close(c);
      if (int'(w[9:0]) != m_dac + 1) begin
        m_err = 2;
        expq.push_back(mk_ev(EvErr, c, 40'd2));
      end
      m_dac = int'(w[9:0]); m_count = 0; m_sat = 1'b0;
    end else if (m_pos == 0 && w == 16'hFF45) begin
      model_close(c);
      expq.push_back(mk_ev(EvDone, c, 40'd0));
      m_mode = 0; m_active = 1'b0;
    end else begin
      expq.push_back(mk_ev(EvData, c, {20'd0, 4'(m_pos), w}));
      m_pos++;
      if (m_pos == PW) begin
        m_pos = 0;
        if (m_count == 65535) begin
          if (!m_sat) begin
            m_sat = 1'b1; m_err = 3;
            expq.push_back(mk_ev(EvErr, c, 40'd3));
          end
        end else begin
          m_count++;
        end
      end
    end
  endfunction

  task automatic send(logic [15:0] w);
    @(negedge Clk);
    InData = w;
    InData_en = 1'b1;
    model_word(w, cyc + 1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      InData_en = 1'b0;
      InData = 16'($urandom);
      if (m_mode != 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          m_gap = 0; m_mode = 0; m_active = 1'b0; m_err = 4;
          expq.push_back(mk_ev(EvErr, cyc + 1, 40'd4));
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset_n = 1'b0;
    InData_en = 1'b0;
    model_clear();
    @(negedge Clk);
    reset_n = 1'b1;
    obs.delete();
    expq.delete();
  endtask

  function automatic logic [15:0] plain_data();
    logic [15:0] w;
    do w = 16'($urandom); while (w[15:10] == 6'b110100 || w == 16'hFF45);
    return w;
  endfunction

  function automatic logic [15:0] rand_word();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return {6'b110100, 10'($urandom)};
    if (r == 1) return 16'hFF45;
    if (r == 2) return 16'h5341;
    return 16'($urandom);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    InData_en = 1'b1;
    InData = 16'h5341;
    repeat (3) @(negedge Clk);
    checks++;
    if ({PackageData, PackageData_en, PackageWordIndex, CurrentDAC, SummaryDAC, SummaryCount,
         Summary_en, SweepActive, SweepDone, ErrorCode, Error_en} !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs got PackageData_en=%b SweepActive=%b ErrorCode=%0d want all 0",
               PackageData_en, SweepActive, ErrorCode);
    end
    InData_en = 1'b0;
    reset_n = 1'b1;
    model_clear();
    obs.delete();
    expq.delete();
  endtask

  task automatic test_nominal();
    do_reset();
    send(16'h5341);
    send(16'hD064);
    repeat (2 * PW) send(plain_data());
    send(16'hD065);
    repeat (PW) send(plain_data());
    send(16'hFF45);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL nominal_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL nominal_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
    checks++;
    if (SummaryDAC !== 10'd101 || SummaryCount !== 16'd1) begin
      failures++;
      $display("FAIL nominal_last_summary got (%0d,%0d) want (101,1)", SummaryDAC, SummaryCount);
    end
    checks++;
    if (ErrorCode !== 3'd0 || SweepActive !== 1'b0) begin
      failures++;
      $display("FAIL nominal_levels got err=%0d active=%b want err=0 active=0",
               ErrorCode, SweepActive);
    end
  endtask

  task automatic test_missing_param();
    do_reset();
    send(16'h5341);
    send(16'h1234);
    send(16'hD064);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL missing_param_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL missing_param_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
    checks++;
    if (ErrorCode !== 3'd1 || SweepActive !== 1'b0) begin
      failures++;
      $display("FAIL missing_param_levels got err=%0d active=%b want err=1 active=0",
               ErrorCode, SweepActive);
    end
  endtask

  task automatic test_dac_sequence();
    do_reset();
    send(16'h5341);
    send(16'hD064);
    repeat (PW) send(plain_data());
    send(16'hD066);
    idle(1);
    checks++;
    if (CurrentDAC !== 10'd102 || ErrorCode !== 3'd2 || SweepActive !== 1'b1) begin
      failures++;
      $display("FAIL dac_seq_levels got dac=%0d err=%0d active=%b want dac=102 err=2 active=1",
               CurrentDAC, ErrorCode, SweepActive);
    end
    repeat (PW) send(plain_data());
    send(16'hD067);
    send(16'hFF45);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL dac_seq_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL dac_seq_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_in_package_markers();
    do_reset();
    send(16'h5341);
    send(16'hD064);
    repeat (5) send(plain_data());
    send(16'hD065);
    send(16'hFF45);
    repeat (PW - 7) send(plain_data());
    send(16'hFF45);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL markers_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL markers_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
    checks++;
    if (CurrentDAC !== 10'd100 || SweepActive !== 1'b0) begin
      failures++;
      $display("FAIL markers_levels got dac=%0d active=%b want dac=100 active=0",
               CurrentDAC, SweepActive);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(16'h5341);
    send(16'hD064);
    repeat (3) send(plain_data());
    idle(TMO + 4);
    checks++;
    if (ErrorCode !== 3'd4 || SweepActive !== 1'b0) begin
      failures++;
      $display("FAIL timeout_levels got err=%0d active=%b want err=4 active=0",
               ErrorCode, SweepActive);
    end
    send(16'hD065);
    send(16'h5341);
    send(16'hD070);
    send(16'hFF45);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL timeout_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL timeout_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(16'h5341);
    send(16'hD064);
    repeat (4) send(plain_data());
    @(negedge Clk);
    reset_n = 1'b0;
    InData_en = 1'b0;
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL reset_mid_pre_count got %0d want %0d", obs.size(), expq.size());
    end
    model_clear();
    @(negedge Clk);
    checks++;
    if ({PackageData, PackageData_en, PackageWordIndex, CurrentDAC, SummaryDAC, SummaryCount,
         Summary_en, SweepActive, SweepDone, ErrorCode, Error_en} !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got data_en=%b dac=%0d active=%b want all 0",
               PackageData_en, CurrentDAC, SweepActive);
    end
    reset_n = 1'b1;
    obs.delete();
    expq.delete();
    send(16'h5341);
    send(16'hD080);
    repeat (PW) send(plain_data());
    send(16'hFF45);
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL reset_mid_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL reset_mid_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_random();
    int nsteps, npk, r;
    do_reset();
    for (int s = 0; s < 30; s++) begin
      send(16'h5341);
      if ($urandom_range(0, 7) == 0) send(rand_word());
      else if ($urandom_range(0, 1) == 1) send({6'b110100, 10'($urandom_range(1019, 1023))});
      else send({6'b110100, 10'($urandom)});
      nsteps = $urandom_range(1, 3);
      for (int st = 0; st < nsteps; st++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk * PW; p++) begin
          send(($urandom_range(0, 3) == 0) ? rand_word() : plain_data());
          if ($urandom_range(0, 9) == 0) begin
            // Gaps of TMO-1 and TMO probe both sides of the timeout edge.
            r = $urandom_range(0, 5);
            idle((r == 0) ? TMO - 1 : (r == 1) ? TMO : r);
          end
        end
        if (st != nsteps - 1) begin
          if ($urandom_range(0, 5) == 0) send({6'b110100, 10'($urandom)});
          else send({6'b110100, 10'(m_dac + 1)});
        end
      end
      if ($urandom_range(0, 5) == 0) idle(TMO + 2);
      else send(16'hFF45);
      idle($urandom_range(0, 3));
    end
    idle(2);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++;
      $display("FAIL random_event_count got %0d want %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        failures++;
        $display("FAIL random_event[%0d] got %h want %h", i, obs[i], expq[i]);
      end
    end
    checks++;
    if (ErrorCode !== 3'(m_err) || SweepActive !== m_active || CurrentDAC !== 10'(m_dac)) begin
      failures++;
      $display("FAIL random_levels got err=%0d active=%b dac=%0d want err=%0d active=%b dac=%0d",
               ErrorCode, SweepActive, CurrentDAC, m_err, m_active, m_dac);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_nominal();
    test_missing_param();
    test_dac_sequence();
    test_in_package_markers();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
